// File: rtl/s2p_frame_sequencer.sv
// s2p_frame_sequencer: streams a parallel word LSB-first into an 8-bit serial-to-parallel
// output register (sclk/sdata), then strobes its latch; also issues on-demand clears.
module s2p_frame_sequencer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             clr_req,
  output logic             sclk,
  output logic             sdata,
  output logic             slatch,
  output logic             sclr,
  output logic             busy,
  output logic             done
);
  localparam int DW = $clog2(DIV + 1);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH);

  typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH, CLEAR, DONE} state_t;

  state_t           state, state_n;
  logic [DW-1:0]    div, div_n;
  logic [BW-1:0]    bcnt, bcnt_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic             tick;

  assign tick = div == DIV_LAST;

  always_comb begin
    state_n = state;
    div_n   = tick ? '0 : div + 1'b1;
    bcnt_n  = bcnt;
    sreg_n  = sreg;
    case (state)
      IDLE: begin
        div_n = '0;
        if (clr_req) state_n = CLEAR;
        else if (in_valid) begin
          state_n = SHIFT_LO;
          sreg_n  = in_data;
          bcnt_n  = '0;
        end
      end
      SHIFT_LO: state_n = tick ? SHIFT_HI : SHIFT_LO;
      SHIFT_HI: if (tick) begin
        sreg_n  = sreg >> 1;
        bcnt_n  = bcnt + 1'b1;
        state_n = (bcnt_n == BIT_LAST) ? LATCH : SHIFT_LO;
      end
      LATCH:   state_n = tick ? DONE : LATCH;
      CLEAR:   state_n = tick ? DONE : CLEAR;
      DONE: begin
        div_n   = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they change only on clk edges.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      div      <= '0;
      bcnt     <= '0;
      sreg     <= '0;
      sclk     <= 1'b0;
      sdata    <= 1'b0;
      slatch   <= 1'b0;
      sclr     <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      in_ready <= 1'b1;
    end else begin
      state    <= state_n;
      div      <= div_n;
      bcnt     <= bcnt_n;
      sreg     <= sreg_n;
      sclk     <= state_n == SHIFT_HI;
      sdata    <= (state_n == SHIFT_LO || state_n == SHIFT_HI) && sreg_n[0];
      slatch   <= state_n == LATCH;
      sclr     <= state_n == CLEAR;
      done     <= state_n == DONE;
      busy     <= state_n != IDLE;
      in_ready <= state_n == IDLE;
    end
  end
endmodule

// File: tb/tb_s2p_frame_sequencer.sv
// tb_s2p_frame_sequencer: directed and random frames on a default (8/4) and a 16/1 instance,
// checked against a behavioural model of the downstream shift/latch register.
module tb_s2p_frame_sequencer;
  logic clk = 0;
  logic reset_n = 1;
  always #5 clk = ~clk;

  logic v8 = 0, clr8 = 0, rdy8, sclk8, sdata8, slat8, sclr8, busy8, done8;
  logic [7:0] d8 = '0;
  logic v16 = 0, clr16 = 0, rdy16, sclk16, sdata16, slat16, sclr16, busy16, done16;
  logic [15:0] d16 = '0;

  s2p_frame_sequencer u_dut8 (
    .clk(clk), .reset_n(reset_n), .in_valid(v8), .in_data(d8), .in_ready(rdy8),
    .clr_req(clr8), .sclk(sclk8), .sdata(sdata8), .slatch(slat8), .sclr(sclr8),
    .busy(busy8), .done(done8)
  );

  s2p_frame_sequencer #(.WIDTH(16), .DIV(1)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .in_valid(v16), .in_data(d16), .in_ready(rdy16),
    .clr_req(clr16), .sclk(sclk16), .sdata(sdata16), .slatch(slat16), .sclr(sclr16),
    .busy(busy16), .done(done16)
  );

  // Downstream register models: shift right on sclk rise with sdata entering the MSB,
  // copy to dataOut on slatch rise, clear both while sclr is high.
  logic [7:0]  sh8 = '0, out8 = '0;
  logic [15:0] sh16 = '0, out16 = '0;
  logic sclk8_q = 0, slat8_q = 0, sclk16_q = 0, slat16_q = 0;

  always @(posedge clk) begin
    if (sclr8) begin
      sh8  <= '0;
      out8 <= '0;
    end else begin
      if (sclk8 && !sclk8_q) sh8 <= {sdata8, sh8[7:1]};
      if (slat8 && !slat8_q) out8 <= sh8;
    end
    if (sclr16) begin
      sh16  <= '0;
      out16 <= '0;
    end else begin
      if (sclk16 && !sclk16_q) sh16 <= {sdata16, sh16[15:1]};
      if (slat16 && !slat16_q) out16 <= sh16;
    end
    sclk8_q  <= sclk8;
    slat8_q  <= slat8;
    sclk16_q <= sclk16;
    slat16_q <= slat16;
  end

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] outs(input bit wide);
    return wide ? {sclk16, sdata16, slat16, sclr16, done16, busy16, rdy16}
                : {sclk8, sdata8, slat8, sclr8, done8, busy8, rdy8};
  endfunction

  // Sends one word and follows it to done; expectations come from the frame rules
  // (bit k on rise k, DIV-cycle phases, latch after the last rise, fixed latency).
  task automatic frame(input bit wide, input logic [15:0] w, input bit hold, input string tag);
    int wd, dv, n, rises, first_rise, last_rise, first_latch;
    logic [15:0] bits, mask;
    bit prev, s, ovl, got;
    wd = wide ? 16 : 8;
    dv = wide ? 1 : 4;
    mask = wide ? 16'hFFFF : 16'h00FF;
    @(negedge clk);
    if (wide) begin v16 = 1; d16 = w; end else begin v8 = 1; d8 = w[7:0]; end
    check({tag, "_ready"}, {31'd0, wide ? rdy16 : rdy8}, 1);
    @(posedge clk);
    #1;
    if (hold) begin
      if (wide) d16 = ~w; else d8 = ~w[7:0];
    end else begin
      if (wide) v16 = 0; else v8 = 0;
    end
    n = 0; rises = 0; first_rise = 0; last_rise = 0; first_latch = 0;
    bits = '0; prev = 0; ovl = 0; got = 0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      s = wide ? sclk16 : sclk8;
      if (s && !prev) begin
        if (rises < 16) bits[rises] = wide ? sdata16 : sdata8;
        if (rises == 0) first_rise = n;
        rises++;
        last_rise = n;
      end
      prev = s;
      if ((wide ? slat16 : slat8) && first_latch == 0) first_latch = n;
      if (int'(s) + int'(wide ? slat16 : slat8) + int'(wide ? sclr16 : sclr8) > 1) ovl = 1;
      got = wide ? done16 : done8;
    end
    check({tag, "_latency"}, n, 2 * dv * wd + dv + 1);
    check({tag, "_rises"}, rises, wd);
    check({tag, "_bits"}, {16'd0, bits}, {16'd0, w & mask});
    check({tag, "_period"}, last_rise - first_rise, 2 * dv * (wd - 1));
    check({tag, "_latch_gap"}, first_latch - last_rise, dv);
    check({tag, "_overlap"}, {31'd0, ovl}, 0);
    check({tag, "_done_flags"}, {30'd0, wide ? busy16 : busy8, wide ? rdy16 : rdy8}, 2'b10);
    check({tag, "_dataout"}, {16'd0, wide ? out16 : out8}, {16'd0, w & mask});
  endtask

  initial begin
    logic [7:0] held;
    int n, rises, sclr_cycles;
    bit prev, toggled, got;

    // 1. reset and idle
    #2 reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs8", {25'd0, outs(0)}, 7'b0000001);
    check("reset_outs16", {25'd0, outs(1)}, 7'b0000001);
    @(negedge clk) reset_n = 1;
    toggled = 0;
    repeat (20) begin
      @(negedge clk);
      if (sclk8 || sclk16) toggled = 1;
    end
    check("idle_no_sclk", {31'd0, toggled}, 0);
    check("idle_outs8", {25'd0, outs(0)}, 7'b0000001);

    // 2. single frame
    frame(0, 16'h00A5, 0, "a5");

    // 3. back-to-back with in_valid held; data changes while busy are ignored
    frame(0, 16'h0001, 1, "b2b_01");
    frame(0, 16'h00FF, 0, "b2b_ff");

    // 4. clear wins over a simultaneous word
    @(negedge clk);
    v8 = 1; d8 = 8'h5A; clr8 = 1;
    check("clr_ready", {31'd0, rdy8}, 1);
    @(posedge clk);
    #1 clr8 = 0;
    n = 0; sclr_cycles = 0; got = 0; prev = 0; rises = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      n++;
      if (sclr8) sclr_cycles++;
      if (sclk8 && !prev) rises++;
      prev = sclk8;
      got = done8;
    end
    check("clr_latency", n, 5);
    check("clr_pulse", sclr_cycles, 4);
    check("clr_no_sclk", rises, 0);
    check("clr_dataout", {24'd0, out8}, 0);
    frame(0, 16'h005A, 0, "after_clr");

    // 5. mid-frame reset abandons the frame
    held = out8;
    @(negedge clk);
    v8 = 1; d8 = 8'h3C;
    @(posedge clk);
    #1 v8 = 0;
    n = 0; rises = 0; prev = 0;
    while (rises < 3 && n < 100) begin
      @(negedge clk);
      n++;
      if (sclk8 && !prev) rises++;
      prev = sclk8;
    end
    check("rst_third_rise", rises, 3);
    reset_n = 0;
    #1;
    check("rst_async_outs", {25'd0, outs(0)}, 7'b0000001);
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (2) @(negedge clk);
    check("rst_no_latch", {24'd0, out8}, {24'd0, held});
    frame(0, 16'h00C3, 0, "c3");

    // 6. 16-bit, DIV=1 instance
    frame(1, 16'h8001, 0, "w16");

    // random words on both instances
    for (int i = 0; i < 4; i++) frame(0, 16'($urandom_range(0, 255)), i[0], "rnd8");
    for (int i = 0; i < 3; i++) frame(1, 16'($urandom), 0, "rnd16");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
